// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  // Tag field sized for the smallest legal cache (1-bit index); larger caches zero-extend.
  localparam int TAG_MAX_W = ADDR_W - 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } dcache_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
    logic [DATA_W-1:0]    data;
  } dcache_line_t;

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines);
    return ADDR_W - 2 - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU data-port and main-memory port of the data cache, bundled for port connection.
interface dcache_ctrl_if;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] miss_count_o;

  // Cache side
  modport slave (
    input  mem_read_i, mem_write_i, addr_i, write_data_i, mem_ready_i, mem_rdata_i,
    output read_data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, miss_count_o
  );

  // CPU + memory environment side
  modport master (
    output mem_read_i, mem_write_i, addr_i, write_data_i, mem_ready_i, mem_rdata_i,
    input  read_data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, miss_count_o
  );
endinterface

// File: rtl/dcache_array.sv
// Line storage: combinational read by index, one synchronous write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int NUM_LINES = 16,
  localparam int INDEX_W   = index_w(NUM_LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output dcache_line_t       rd_line,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  dcache_line_t       wr_line
);

  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;
  logic [TAG_MAX_W-1:0] tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES];

  // Only the state bits are cleared; tag/data contents are meaningless until valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (we) begin
      valid_reg[wr_index] <= wr_line.valid;
      dirty_reg[wr_index] <= wr_line.dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_line.tag;
      data_mem[wr_index] <= wr_line.data;
    end
  end

  always_comb begin
    rd_line.valid = valid_reg[rd_index];
    rd_line.dirty = dirty_reg[rd_index];
    rd_line.tag   = tag_mem[rd_index];
    rd_line.data  = data_mem[rd_index];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hit path, miss FSM,
// main-memory req/ready handshake and miss counter.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  dcache_ctrl_if.slave bus
);

  localparam int INDEX_W = index_w(NUM_LINES);
  localparam int TAG_W   = tag_w(NUM_LINES);

  dcache_state_e      state_reg, state_next;
  logic [31:0]        miss_count_reg;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  dcache_line_t       line, wr_line;
  logic               wr_en, is_write, is_read, hit, victim_dirty, miss;
  logic               unused_addr_bits;

  assign index            = bus.addr_i[INDEX_W+1:2];
  assign tag              = bus.addr_i[31:INDEX_W+2];
  assign unused_addr_bits = ^bus.addr_i[1:0];
  // A store wins when both request strobes are high.
  assign is_write         = bus.mem_write_i;
  assign is_read          = bus.mem_read_i & ~bus.mem_write_i;
  assign hit              = line.valid && (line.tag == TAG_MAX_W'(tag));
  assign victim_dirty     = line.valid & line.dirty;
  assign miss             = (state_reg == IDLE) && (is_read || is_write) && !hit;
  assign bus.miss_count_o = miss_count_reg;

  dcache_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clk      (clk_i),
    .rst      (rst_i),
    .rd_index (index),
    .rd_line  (line),
    .we       (wr_en),
    .wr_index (index),
    .wr_line  (wr_line)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     miss_count_reg <= '0;
    else if (miss) miss_count_reg <= miss_count_reg + 32'd1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (miss) begin
          if (victim_dirty) state_next = WRITE_BACK;
          else if (is_read) state_next = ALLOCATE;
        end
      end
      WRITE_BACK: if (bus.mem_ready_i) state_next = is_read ? ALLOCATE : IDLE;
      ALLOCATE:   if (bus.mem_ready_i) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.stall_o     = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.read_data_o = '0;
    wr_en           = 1'b0;
    wr_line.valid   = 1'b1;
    wr_line.dirty   = 1'b1;
    wr_line.tag     = TAG_MAX_W'(tag);
    wr_line.data    = bus.write_data_i;
    case (state_reg)
      IDLE: begin
        // A store miss over a clean victim installs directly without stalling.
        bus.stall_o = miss && (is_read || victim_dirty);
        if (is_read && hit) bus.read_data_o = line.data;
        wr_en = is_write && (hit || !victim_dirty);
      end
      WRITE_BACK: begin
        bus.stall_o     = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {line.tag[TAG_W-1:0], index, 2'b00};
        bus.mem_wdata_o = line.data;
        wr_en           = is_write && bus.mem_ready_i;
      end
      ALLOCATE: begin
        bus.stall_o   = 1'b1;
        bus.mem_req_o = 1'b1;
        bus.mem_addr_o = {bus.addr_i[31:2], 2'b00};
        wr_en         = bus.mem_ready_i;
        wr_line.dirty = 1'b0;
        wr_line.data  = bus.mem_rdata_i;
      end
      default: ;
    endcase
    if (rst_i) bus.stall_o = 1'b0;
  end

endmodule
